serial_alu_seq: RTL
===================

# serial_alu_seq

Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice and drives it one bit per cycle. It accepts WIDTH-bit operands and a MIPS funct code over a valid/ready handshake, then presents LSB-first operand bits, carry-in and select to the slice. It collects the slice's sum/logic bit and carry-out each cycle, and returns the assembled result with flags over a second valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_funct  input  6  funct code: 6'd32 ADD, 6'd34 SUB, 6'd36 AND, 6'd37 OR
- alu_a  output  1  current A bit to slice
- alu_b  output  1  current B bit to slice (uninverted; slice inverts for SUB)
- alu_cin  output  1  carry-in to slice
- alu_sel  output  6  select to slice
- alu_out  input  1  slice result bit
- alu_cout  input  1  slice carry-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  assembled result
- out_carry  output  1  final carry-out (ADD/SUB only, else 0)
- out_zero  output  1  out_result == 0
- out_err  output  1  unsupported funct

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, capture in_a, in_b and in_funct into a_q, b_q and f_q, and clear bit counter, carry_q and result.
  - Supported funct: go to RUN.
  - Unsupported funct: go to DONE with result 0 and err=1.
- RUN: in_ready=0. Slice drive:
  - alu_a=a_q[0], alu_b=b_q[0], alu_sel=f_q.
  - alu_cin = (cnt==0) ? (f_q==SUB) : carry_q.
- Each RUN cycle:
  - a_q and b_q shift right by 1.
  - result shifts right with alu_out entering at MSB.
  - carry_q <= alu_cout.
  - cnt increments.
  - At cnt==WIDTH-1, capture the final cout into out_carry (forced 0 for AND/OR) and go to DONE.
- DONE: out_valid=1 and outputs held stable until out_ready; then go to IDLE.
- No request is accepted in the same cycle as the output handshake, so there is one IDLE cycle minimum between jobs.
- Outside RUN: alu_a, alu_b, alu_cin = 0 and alu_sel = 6'd0 (slice outputs 0).
- out_zero is registered alongside out_result.
- Arithmetic is modulo 2^WIDTH. SUB computes A + ~B + 1, so out_carry=1 means no borrow.

## Timing
- Reset (rst_n low at a clk edge, from any state, including mid-RUN): next state IDLE, job aborted.
  - in_ready=1.
  - out_valid=0, out_result=0, out_carry=0, out_zero=0, out_err=0.
  - alu_* = 0, cnt=0, carry_q=0.
- Supported op: accept edge at cycle 0; RUN occupies cycles 1..WIDTH; out_valid is asserted from cycle WIDTH+1.
- Unsupported op: out_valid asserted from cycle 1.
- Slice is combinational; alu_out and alu_cout are sampled on the same edge as the drive they depend on.
- out_* must not change while out_valid=1 and out_ready=0.
- in_valid while in_ready=0 is ignored; the upstream stage holds it.

## Configuration
- SERIAL_ALU_OVF_EN defined: adds output out_ovf (1 bit), signed overflow.
  - For ADD/SUB: out_ovf = carry_q ^ alu_cout, captured at cnt==WIDTH-1 (carry into MSB xor carry out of MSB).
  - 0 for AND, OR and err; reset value 0.
- SERIAL_ALU_OVF_EN undefined: port and logic absent; all other behaviour identical.

## Structure
- Package serial_alu_pkg:
  - funct localparams FUNCT_ADD=6'd32, FUNCT_SUB=6'd34, FUNCT_AND=6'd36, FUNCT_OR=6'd37.
  - state encoding IDLE/RUN/DONE.
  - is_supported(funct) function.
- The slice stays outside this block. The natural sub-module is the bench/top wrapper serial_alu_top, which instantiates serial_alu_seq plus one 1-bit ALU slice.

## Test plan
- ADD 5+3 (WIDTH=32) -> out_result=8, carry=0, zero=0, out_valid exactly 33 cycles after accept.
- SUB 3-5 -> 0xFFFFFFFE, carry=0. SUB 5-5 -> 0, zero=1, carry=1.
- AND 0xF0F0_00FF & 0x0FF0_0F0F -> 0x00F0_000F. OR of the same operands -> 0xFFF0_0FFF. carry=0 for both.
- in_funct=6'd42 -> out_err=1, result 0, out_valid 1 cycle after accept, no RUN cycles (alu_sel stays 0).
- out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0. Then a single-cycle out_ready -> IDLE; a back-to-back request is accepted one cycle later.
- rst_n low during RUN at cnt=10 -> IDLE next edge with all outputs at reset values; a following ADD 0x7FFFFFFF+1 gives 0x80000000, and with SERIAL_ALU_OVF_EN gives out_ovf=1.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared funct codes, FSM state encoding and funct decode helper for the bit-serial ALU sequencer.
package serial_alu_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_supported(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_AND) || (funct == FUNCT_OR);
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Request/response handshake bundle of serial_alu_seq; out_ovf exists only with SERIAL_ALU_OVF_EN.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [5:0]       in_funct;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
`ifdef SERIAL_ALU_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_funct, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_err
`ifdef SERIAL_ALU_OVF_EN
      , input  out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_funct, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_err
`ifdef SERIAL_ALU_OVF_EN
      , output out_ovf
`endif
    );

endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice LSB-first and assembling its result.
// Optional signed-overflow flag (out_ovf) enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_alu_seq_if.slave        bus,
    output logic                   alu_a,
    output logic                   alu_b,
    output logic                   alu_cin,
    output logic [5:0]             alu_sel,
    input  logic                   alu_out,
    input  logic                   alu_cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [5:0]       f_q, f_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_carry_q, out_carry_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q, out_err_d;
`ifdef SERIAL_ALU_OVF_EN
    logic             out_ovf_q, out_ovf_d;
`endif

    logic [WIDTH-1:0] res_shift;
    logic             is_arith;

    // Operand/select/carry flops are zero outside RUN, so the slice drive comes straight off them.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        f_d         = f_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_carry_d = out_carry_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
`ifdef SERIAL_ALU_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif
        res_shift   = {alu_out, res_q[WIDTH-1:1]};
        is_arith    = (f_q == FUNCT_ADD) || (f_q == FUNCT_SUB);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_d       = '0;
                    res_d       = '0;
                    out_carry_d = 1'b0;
                    in_ready_d  = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                    out_ovf_d   = 1'b0;
`endif
                    if (is_supported(bus.in_funct)) begin
                        a_d        = bus.in_a;
                        b_d        = bus.in_b;
                        f_d        = bus.in_funct;
                        carry_d    = (bus.in_funct == FUNCT_SUB);
                        out_zero_d = 1'b0;
                        out_err_d  = 1'b0;
                        state_d    = RUN;
                    end else begin
                        out_zero_d  = 1'b1;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = alu_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    out_carry_d = is_arith & alu_cout;
`ifdef SERIAL_ALU_OVF_EN
                    out_ovf_d   = is_arith & (carry_q ^ alu_cout);
`endif
                    out_zero_d  = (res_shift == '0);
                    out_valid_d = 1'b1;
                    a_d         = '0;
                    b_d         = '0;
                    f_d         = '0;
                    carry_d     = 1'b0;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_carry_q <= out_carry_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
`ifdef SERIAL_ALU_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign alu_a          = a_q[0];
    assign alu_b          = b_q[0];
    assign alu_cin        = carry_q;
    assign alu_sel        = f_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_carry  = out_carry_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_err    = out_err_q;
`ifdef SERIAL_ALU_OVF_EN
    assign bus.out_ovf    = out_ovf_q;
`endif

endmodule
